generador_pulsos: RTL and testbench
===================================

Name: generador_pulsos

Overview:
Transmit-side counterpart of the team's falling-edge/flank detector used on button inputs. It converts single-cycle event strobes into clean, minimum-width level pulses timed in clock-enable ticks: high for HIGH_TICKS samples, then a guaranteed low guard of LOW_TICKS samples. Any detector sampling on the same enable therefore sees exactly one valid high-then-low pattern per event. Requests arriving while a pulse is in progress are queued in a saturating pending counter.

Parameters:
HIGH_TICKS, 4, number of icle ticks osalida is held high per event (>=1)
LOW_TICKS, 4, number of icle ticks osalida is held low after each pulse (>=1)
PEND_W, 3, width of pending-request counter; max queued = 2^PEND_W-1

Ports:
iclk  input  1  clock
ireset  input  1  synchronous, active-high reset; clock iclk
icle  input  1  sample-tick enable; timing counters advance only when 1
idisparo  input  1  event strobe, sampled every clock (not gated by icle); each high cycle = one request
osalida  output  1  registered pulse output
obusy  output  1  high when state != IDLE or opendientes != 0
opendientes  output  PEND_W  queued requests not yet started
ooverflow  output  1  sticky: a request arrived while opendientes was saturated

Behaviour:
- ireset has priority over everything, including icle. On reset: state=IDLE, tick counter=0, osalida=0, opendientes=0, ooverflow=0. A reset mid-pulse forces osalida=0 on the next edge and discards all queued requests.
- Pending counter, updated every clock:
  - +1 if idisparo=1; -1 if a pulse starts this cycle; both in the same cycle = unchanged.
  - Saturates at 2^PEND_W-1. If idisparo=1 at saturation with no simultaneous start: the count stays and ooverflow is set to 1. ooverflow clears only on reset.
- Tick counter width = clog2(max(HIGH_TICKS, LOW_TICKS)). It is loaded to 0 on every state entry.
- FSM, three states:
  - IDLE: osalida=0. If icle=1 and opendientes>0 (registered value): go to HIGH and dequeue one request.
  - HIGH: osalida=1. On icle=1: if cnt==HIGH_TICKS-1, go to LOW; else cnt+1. When icle=0: hold.
  - LOW: osalida=0. On icle=1 with cnt==LOW_TICKS-1: if opendientes>0, go to HIGH and dequeue; else go to IDLE. Otherwise on icle=1: cnt+1. When icle=0: hold.
- osalida is a registered decode of state==HIGH. It changes on the clock edge that consumes the icle tick.
- Latency with icle held at 1:
  - idisparo at cycle 0 → opendientes=1 after edge 1 → osalida=1 after edge 2.
  - osalida stays high exactly HIGH_TICKS cycles, then low for at least LOW_TICKS cycles.
- Queued requests never shorten the LOW guard. Back-to-back events are separated by exactly LOW_TICKS ticks of low.
- idisparo held high for N cycles counts as N requests. Upstream logic must supply single-cycle strobes.
- With icle=0 permanently, requests accumulate and no pulse starts.

Test Plan:
1. Defaults, icle=1 constant, single idisparo pulse at cycle 0 → osalida=1 for cycles 2..5, 0 from cycle 6. opendientes shows 1 only during cycle 1. obusy falls after cycle 9.
2. icle=1 every 4th clock, single request → osalida high 16 clocks, then low 16 clocks before obusy=0. Edges of osalida align with icle clocks.
3. icle=1 constant, idisparo high 3 consecutive cycles → three 4-cycle high pulses, each separated by exactly 4 low cycles. opendientes sequence peaks at 2. ooverflow stays 0.
4. icle=0, idisparo high for 8 cycles → opendientes=7, ooverflow=1. Then icle=1 → exactly 7 output pulses, opendientes reaches 0, ooverflow remains 1.
5. Reset asserted during the 2nd high cycle with opendientes=2 → after the next edge, osalida=0, opendientes=0, ooverflow=0, obusy=0. A subsequent single request behaves exactly as in test 1.
6. Loopback: osalida drives the button flank detector on the same iclk/icle. Send 5 requests at random spacing → the detector emits exactly 5 single-cycle pulses, each one tick after an osalida falling edge.

Source files
------------

// File: rtl/generador_pulsos.sv
// Turns single-cycle event strobes into high/low pulses timed in icle ticks.
// Requests that arrive during a pulse are queued in a saturating counter.
module generador_pulsos #(
    parameter int HIGH_TICKS = 4,
    parameter int LOW_TICKS  = 4,
    parameter int PEND_W     = 3
) (
    input  logic              iclk,
    input  logic              ireset,
    input  logic              icle,
    input  logic              idisparo,
    output logic              osalida,
    output logic              obusy,
    output logic [PEND_W-1:0] opendientes,
    output logic              ooverflow
);

    localparam int MAX_TICKS = (HIGH_TICKS > LOW_TICKS) ? HIGH_TICKS : LOW_TICKS;
    // A one-tick pulse and guard would need a zero-width counter, so keep at least one bit.
    localparam int CNT_W = (MAX_TICKS > 1) ? $clog2(MAX_TICKS) : 1;

    localparam logic [CNT_W-1:0]  HIGH_LAST = CNT_W'(HIGH_TICKS - 1);
    localparam logic [CNT_W-1:0]  LOW_LAST  = CNT_W'(LOW_TICKS - 1);
    localparam logic [PEND_W-1:0] PEND_MAX  = '1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_HIGH,
        ST_LOW
    } estado_t;

    estado_t           r_estado;
    estado_t           w_sig_estado;
    logic [CNT_W-1:0]  r_cnt;
    logic [CNT_W-1:0]  w_sig_cnt;
    logic [PEND_W-1:0] r_pend;
    logic              r_ovf;
    logic              r_salida;
    logic              w_inicio;
    logic              w_hay_pend;

    assign w_hay_pend = (r_pend != '0);

    always_comb begin
        // NOTE: every output of this block is defaulted first so no path leaves a latch.
        w_sig_estado = r_estado;
        w_sig_cnt    = r_cnt;
        w_inicio     = 1'b0;
        case (r_estado)
            ST_IDLE: begin
                if (icle && w_hay_pend) begin
                    w_sig_estado = ST_HIGH;
                    w_sig_cnt    = '0;
                    w_inicio     = 1'b1;
                end
            end
            ST_HIGH: begin
                if (icle) begin
                    if (r_cnt == HIGH_LAST) begin
                        w_sig_estado = ST_LOW;
                        w_sig_cnt    = '0;
                    end else begin
                        w_sig_cnt = r_cnt + 1'b1;
                    end
                end
            end
            ST_LOW: begin
                if (icle) begin
                    if (r_cnt == LOW_LAST) begin
                        w_sig_cnt = '0;
                        if (w_hay_pend) begin
                            w_sig_estado = ST_HIGH;
                            w_inicio     = 1'b1;
                        end else begin
                            w_sig_estado = ST_IDLE;
                        end
                    end else begin
                        w_sig_cnt = r_cnt + 1'b1;
                    end
                end
            end
            default: begin
                w_sig_estado = ST_IDLE;
                w_sig_cnt    = '0;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_estado <= ST_IDLE;
            r_cnt    <= '0;
            r_salida <= 1'b0;
        end else begin
            r_estado <= w_sig_estado;
            r_cnt    <= w_sig_cnt;
            r_salida <= (w_sig_estado == ST_HIGH);
        end
    end

    // A strobe and a dequeue in the same cycle cancel; a strobe at saturation only flags overflow.
    always_ff @(posedge iclk) begin
        if (ireset) begin
            r_pend <= '0;
            r_ovf  <= 1'b0;
        end else begin
            case ({idisparo, w_inicio})
                2'b10: begin
                    if (r_pend == PEND_MAX) begin
                        r_ovf <= 1'b1;
                    end else begin
                        r_pend <= r_pend + 1'b1;
                    end
                end
                2'b01:   r_pend <= r_pend - 1'b1;
                default: r_pend <= r_pend;
            endcase
        end
    end

    assign osalida     = r_salida;
    assign opendientes = r_pend;
    assign ooverflow   = r_ovf;
    assign obusy       = (r_estado != ST_IDLE) || w_hay_pend;

endmodule

// File: tb/tb_generador_pulsos.sv
// Directed bench for generador_pulsos with default parameters (4/4/3),
// including a loopback through a falling-edge detector model.
module tb_generador_pulsos;

    logic       iclk = 1'b0;
    logic       ireset;
    logic       icle;
    logic       idisparo;
    logic       osalida;
    logic       obusy;
    logic [2:0] opendientes;
    logic       ooverflow;

    int n_checks = 0;
    int n_fail   = 0;

    generador_pulsos #(
        .HIGH_TICKS(4),
        .LOW_TICKS (4),
        .PEND_W    (3)
    ) dut (
        .iclk       (iclk),
        .ireset     (ireset),
        .icle       (icle),
        .idisparo   (idisparo),
        .osalida    (osalida),
        .obusy      (obusy),
        .opendientes(opendientes),
        .ooverflow  (ooverflow)
    );

    always #5 iclk = ~iclk;

    // Falling-edge detector on the same clock and enable, fed by osalida.
    logic r_muestra;
    logic r_flanco;
    always @(posedge iclk) begin
        if (ireset) begin
            r_muestra <= 1'b0;
            r_flanco  <= 1'b0;
        end else begin
            r_flanco <= icle & r_muestra & ~osalida;
            if (icle) r_muestra <= osalida;
        end
    end

    // Mid-cycle monitor for the loopback scenario.
    logic mon_en = 1'b0;
    int   mon_cyc, mon_last_fall, mon_falls, det_count, det_bad;
    logic mon_prev_sal, mon_prev_det;
    always @(negedge iclk) begin
        if (mon_en) begin
            mon_cyc = mon_cyc + 1;
            if (mon_prev_sal && !osalida) begin
                mon_last_fall = mon_cyc;
                mon_falls     = mon_falls + 1;
            end
            if (r_flanco) begin
                det_count = det_count + 1;
                if (mon_cyc != mon_last_fall + 1 || mon_prev_det) det_bad = det_bad + 1;
            end
            mon_prev_sal = osalida;
            mon_prev_det = r_flanco;
        end
    end

    task automatic tick();
        @(posedge iclk);
        #1;
    endtask

    task automatic apply_reset();
        ireset   = 1'b1;
        icle     = 1'b1;
        idisparo = 1'b0;
        tick();
        tick();
        ireset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        n_checks += 4;
        if (osalida !== 1'b0) begin n_fail++; $display("FAIL reset_osalida: got %b expected 0", osalida); end
        if (opendientes !== 3'd0) begin n_fail++; $display("FAIL reset_pend: got %0d expected 0", opendientes); end
        if (ooverflow !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b expected 0", ooverflow); end
        if (obusy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b expected 0", obusy); end
    endtask

    // One strobe at cycle 0 with icle=1: high cycles 2..5, busy 1..9, pending 1 only in cycle 1.
    task automatic run_single_profile(input string tag);
        logic       exp_sal, exp_busy;
        logic [2:0] exp_pend;
        icle = 1'b1;
        for (int c = 0; c <= 12; c++) begin
            exp_sal  = (c >= 2 && c <= 5);
            exp_busy = (c >= 1 && c <= 9);
            exp_pend = (c == 1) ? 3'd1 : 3'd0;
            n_checks += 3;
            if (osalida !== exp_sal) begin n_fail++; $display("FAIL %s_sal c=%0d: got %b expected %b", tag, c, osalida, exp_sal); end
            if (obusy !== exp_busy) begin n_fail++; $display("FAIL %s_busy c=%0d: got %b expected %b", tag, c, obusy, exp_busy); end
            if (opendientes !== exp_pend) begin n_fail++; $display("FAIL %s_pend c=%0d: got %0d expected %0d", tag, c, opendientes, exp_pend); end
            idisparo = (c == 0);
            tick();
        end
        idisparo = 1'b0;
    endtask

    task automatic test_single();
        apply_reset();
        run_single_profile("single");
    endtask

    // icle every 4th clock: high cycles 5..20, low guard until busy drops at cycle 37.
    task automatic test_slow_enable();
        logic exp_sal, exp_busy;
        apply_reset();
        for (int c = 0; c <= 40; c++) begin
            exp_sal  = (c >= 5 && c <= 20);
            exp_busy = (c >= 1 && c <= 36);
            n_checks += 2;
            if (osalida !== exp_sal) begin n_fail++; $display("FAIL slow_sal c=%0d: got %b expected %b", c, osalida, exp_sal); end
            if (obusy !== exp_busy) begin n_fail++; $display("FAIL slow_busy c=%0d: got %b expected %b", c, obusy, exp_busy); end
            icle     = ((c % 4) == 0);
            idisparo = (c == 0);
            tick();
        end
        icle     = 1'b1;
        idisparo = 1'b0;
    endtask

    // Three consecutive strobes: highs at 2..5, 10..13, 18..21; pending 1,1,2..2,1..1,0.
    task automatic test_back_to_back();
        logic       exp_sal, exp_busy;
        logic [2:0] exp_pend;
        apply_reset();
        for (int c = 0; c <= 30; c++) begin
            exp_sal  = (c >= 2 && c <= 21 && ((c - 2) % 8) < 4);
            exp_busy = (c >= 1 && c <= 25);
            if (c >= 1 && c <= 2)       exp_pend = 3'd1;
            else if (c >= 3 && c <= 9)  exp_pend = 3'd2;
            else if (c >= 10 && c <= 17) exp_pend = 3'd1;
            else                        exp_pend = 3'd0;
            n_checks += 4;
            if (osalida !== exp_sal) begin n_fail++; $display("FAIL b2b_sal c=%0d: got %b expected %b", c, osalida, exp_sal); end
            if (obusy !== exp_busy) begin n_fail++; $display("FAIL b2b_busy c=%0d: got %b expected %b", c, obusy, exp_busy); end
            if (opendientes !== exp_pend) begin n_fail++; $display("FAIL b2b_pend c=%0d: got %0d expected %0d", c, opendientes, exp_pend); end
            if (ooverflow !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf c=%0d: got %b expected 0", c, ooverflow); end
            icle     = 1'b1;
            idisparo = (c <= 2);
            tick();
        end
        idisparo = 1'b0;
    endtask

    // Eight strobes with icle=0 saturate at 7 and set overflow; then exactly 7 pulses drain it.
    task automatic test_overflow();
        int   pulses, run, budget;
        logic prev;
        apply_reset();
        icle     = 1'b0;
        idisparo = 1'b1;
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (osalida !== 1'b0) begin n_fail++; $display("FAIL ovf_nopulse c=%0d: got %b expected 0", c, osalida); end
        end
        idisparo = 1'b0;
        tick();
        n_checks += 2;
        if (opendientes !== 3'd7) begin n_fail++; $display("FAIL ovf_pend_sat: got %0d expected 7", opendientes); end
        if (ooverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_flag: got %b expected 1", ooverflow); end
        icle   = 1'b1;
        pulses = 0;
        run    = 0;
        prev   = 1'b0;
        budget = 0;
        while (obusy && budget < 200) begin
            tick();
            budget++;
            if (osalida) begin
                if (!prev) pulses++;
                run++;
            end else if (prev) begin
                n_checks++;
                if (run != 4) begin n_fail++; $display("FAIL ovf_width pulse=%0d: got %0d expected 4", pulses, run); end
                run = 0;
            end
            prev = osalida;
        end
        n_checks += 4;
        if (budget >= 200) begin n_fail++; $display("FAIL ovf_timeout: got %0d cycles expected under 200", budget); end
        if (pulses != 7) begin n_fail++; $display("FAIL ovf_pulses: got %0d expected 7", pulses); end
        if (opendientes !== 3'd0) begin n_fail++; $display("FAIL ovf_drain: got %0d expected 0", opendientes); end
        if (ooverflow !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b expected 1", ooverflow); end
    endtask

    // Entered with ooverflow still set from the previous test, so reset must clear it.
    task automatic test_reset_mid_pulse();
        icle = 1'b1;
        for (int c = 0; c < 3; c++) begin
            idisparo = 1'b1;
            tick();
        end
        idisparo = 1'b0;
        n_checks += 3;
        if (osalida !== 1'b1) begin n_fail++; $display("FAIL rst_pre_sal: got %b expected 1", osalida); end
        if (opendientes !== 3'd2) begin n_fail++; $display("FAIL rst_pre_pend: got %0d expected 2", opendientes); end
        if (ooverflow !== 1'b1) begin n_fail++; $display("FAIL rst_pre_ovf: got %b expected 1", ooverflow); end
        ireset = 1'b1;
        tick();
        ireset = 1'b0;
        n_checks += 4;
        if (osalida !== 1'b0) begin n_fail++; $display("FAIL rst_mid_sal: got %b expected 0", osalida); end
        if (opendientes !== 3'd0) begin n_fail++; $display("FAIL rst_mid_pend: got %0d expected 0", opendientes); end
        if (ooverflow !== 1'b0) begin n_fail++; $display("FAIL rst_mid_ovf: got %b expected 0", ooverflow); end
        if (obusy !== 1'b0) begin n_fail++; $display("FAIL rst_mid_busy: got %b expected 0", obusy); end
        run_single_profile("after_rst");
    endtask

    task automatic test_loopback();
        int budget;
        apply_reset();
        mon_cyc       = 0;
        mon_last_fall = -10;
        mon_falls     = 0;
        det_count     = 0;
        det_bad       = 0;
        mon_prev_sal  = 1'b0;
        mon_prev_det  = 1'b0;
        mon_en        = 1'b1;
        icle          = 1'b1;
        for (int k = 0; k < 5; k++) begin
            idisparo = 1'b1;
            tick();
            idisparo = 1'b0;
            repeat ($urandom_range(15, 1)) tick();
        end
        budget = 0;
        while (obusy && budget < 300) begin
            tick();
            budget++;
        end
        repeat (4) tick();
        mon_en = 1'b0;
        n_checks += 4;
        if (budget >= 300) begin n_fail++; $display("FAIL loop_timeout: got %0d cycles expected under 300", budget); end
        if (mon_falls != 5) begin n_fail++; $display("FAIL loop_falls: got %0d expected 5", mon_falls); end
        if (det_count != 5) begin n_fail++; $display("FAIL loop_detections: got %0d expected 5", det_count); end
        if (det_bad != 0) begin n_fail++; $display("FAIL loop_timing: got %0d misplaced expected 0", det_bad); end
    endtask

    initial begin
        ireset   = 1'b1;
        icle     = 1'b0;
        idisparo = 1'b0;
        test_reset();
        test_single();
        test_slow_enable();
        test_back_to_back();
        test_overflow();
        test_reset_mid_pulse();
        test_loopback();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
